// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_I,
    ARB_WAIT_D
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
module arb_streak_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port, one transaction in flight.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_done,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_done,
  output logic                    StallFetchM,
  output logic                    StallMemM,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  if (MAX_DATA_STREAK < 1) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be at least 1");
  end

  arb_state_t state, state_nx;
  logic       discard, discard_nx;
  arb_owner_t owner;
  logic       sel_valid;
  logic       guard_fetch;

  logic                    req_c, we_c, if_done_c, dm_done_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [DATA_WIDTH-1:0]   wdata_c;
  logic [DATA_WIDTH/8-1:0] wstrb_c;

  // Data normally wins; the guard hands the tie to fetch once data has streaked too long.
  always_comb begin
    owner     = OWN_DM;
    sel_valid = 1'b0;
    if (dm_req && !guard_fetch) begin
      owner     = OWN_DM;
      sel_valid = 1'b1;
    end else if (if_req && !if_flush) begin
      owner     = OWN_IF;
      sel_valid = 1'b1;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic at_max, data_grant, fetch_grant;

  assign data_grant  = (state == ARB_IDLE) && sel_valid && (owner == OWN_DM) && mem_gnt;
  assign fetch_grant = (state == ARB_IDLE) && sel_valid && (owner == OWN_IF) && mem_gnt;

  arb_streak_counter #(.MAX(MAX_DATA_STREAK)) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fetch_grant || !if_req),
    .inc    (data_grant && if_req),
    .at_max (at_max)
  );

  assign guard_fetch = at_max && if_req && !if_flush;
`else
  assign guard_fetch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      discard <= 1'b0;
    end else begin
      state   <= state_nx;
      discard <= discard_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    wstrb_c    = '0;
    if_done_c  = 1'b0;
    dm_done_c  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        discard_nx = 1'b0;
        if (sel_valid) begin
          req_c = 1'b1;
          if (owner == OWN_DM) begin
            we_c    = dm_we;
            addr_c  = dm_addr;
            wdata_c = dm_wdata;
            wstrb_c = dm_wstrb;
          end else begin
            addr_c = if_addr;
          end
          if (mem_gnt) begin
            state_nx = (owner == OWN_DM) ? ARB_WAIT_D : ARB_WAIT_I;
          end
        end
      end
      ARB_WAIT_I: begin
        // A flush arriving together with the response also kills the stale instruction.
        if (mem_rvalid) begin
          if_done_c  = !discard && !if_flush;
          discard_nx = 1'b0;
          state_nx   = ARB_IDLE;
        end else if (if_flush) begin
          discard_nx = 1'b1;
        end
      end
      ARB_WAIT_D: begin
        if (mem_rvalid) begin
          dm_done_c = 1'b1;
          state_nx  = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign mem_req     = rst_n && req_c;
  assign mem_we      = rst_n && we_c;
  assign mem_addr    = rst_n ? addr_c  : '0;
  assign mem_wdata   = rst_n ? wdata_c : '0;
  assign mem_wstrb   = rst_n ? wstrb_c : '0;
  assign if_done     = rst_n && if_done_c;
  assign dm_done     = rst_n && dm_done_c;
  assign if_rdata    = if_done ? mem_rdata : '0;
  assign dm_rdata    = dm_done ? mem_rdata : '0;
  assign StallFetchM = rst_n && if_req && !if_done_c;
  assign StallMemM   = rst_n && dm_req && !dm_done_c;

  a_dm_held : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_WAIT_D) |-> dm_req);
  a_if_held : assert property (@(posedge clk) disable iff (!rst_n)
    (state == ARB_WAIT_I && !discard && !if_flush) |-> if_req);

endmodule
